// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel valid/ready mux into a one-entry output register, fixed or round-robin select.
// Round-robin mode and its pointer exist only when MUX_RR_EN is defined; otherwise M is ignored.
module mux_rr_n #(
  parameter int WIDTH = 8,
  parameter int SW    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(2**SW)*WIDTH-1:0]      X,
  input  logic [2**SW-1:0]              V,
  output logic [2**SW-1:0]              R,
  input  logic                          M,
  input  logic [SW-1:0]                 S,
  output logic [WIDTH-1:0]              Y,
  output logic                          YV,
  input  logic                          YR,
  output logic [SW-1:0]                 YC
);
  localparam int N = 2**SW;
  logic             load, gv;
  logic [SW-1:0]    gi;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SW-1:0]    yc_q, yc_d;
  logic             yv_q, yv_d;
`ifdef MUX_RR_EN
  logic [SW-1:0]    p_q, p_d;
  // Descending scan so the last write is the first valid channel at or after p_q.
  always_comb begin
    gi = S;
    gv = V[S];
    if (M) begin
      gv = |V;
      gi = p_q;
      for (int k = N - 1; k >= 0; k--)
        if (V[p_q + SW'(k)]) gi = p_q + SW'(k);
    end
    p_d = (M & load & gv) ? gi + SW'(1) : p_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) p_q <= '0;
    else     p_q <= p_d;
`else
  logic unused_m;
  assign unused_m = M;
  assign gi = S;
  assign gv = V[S];
`endif
  assign load = ~yv_q | YR;
  assign R    = (load & gv & ~rst) ? {{(N-1){1'b0}}, 1'b1} << gi : '0;
  always_comb begin
    y_d  = (load & gv) ? X[gi*WIDTH +: WIDTH] : y_q;
    yc_d = (load & gv) ? gi : yc_q;
    yv_d = load ? gv : yv_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y_q  <= '0;
      yc_q <= '0;
      yv_q <= 1'b0;
    end else begin
      y_q  <= y_d;
      yc_q <= yc_d;
      yv_q <= yv_d;
    end
  assign Y  = y_q;
  assign YC = yc_q;
  assign YV = yv_q;
endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: randomized and directed checks of mux_rr_n against a behavioural reference model.
module tb_mux_rr_n;
  localparam int W = 8, SW = 2, N = 4;
  logic clk = 1'b0, rst;
  logic [N*W-1:0] X;
  logic [N-1:0] V, R;
  logic M, YV, YR;
  logic [SW-1:0] S, YC;
  logic [W-1:0] Y;
  int tests = 0, fails = 0;
  int mp, myc;
  logic [W-1:0] my;
  bit myv;

  mux_rr_n #(.WIDTH(W), .SW(SW)) dut (
    .clk(clk), .rst(rst), .X(X), .V(V), .R(R), .M(M), .S(S),
    .Y(Y), .YV(YV), .YR(YR), .YC(YC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Channel that must win this cycle, or -1.
  function automatic int grant();
`ifdef MUX_RR_EN
    if (M) begin
      for (int k = 0; k < N; k++) if (V[(mp + k) % N]) return (mp + k) % N;
      return -1;
    end
`endif
    return V[S] ? int'(S) : -1;
  endfunction

  task automatic model_reset();
    mp = 0; my = '0; myc = 0; myv = 0;
  endtask

  task automatic compare();
    int g;
    logic [N-1:0] er;
    g = grant();
    er = (!rst && (!myv || YR) && g >= 0) ? N'(1) << g : '0;
    chk("R", 32'(R), 32'(er));
    chk("Y", 32'(Y), 32'(my));
    chk("YV", 32'(YV), 32'(myv));
    chk("YC", 32'(YC), 32'(myc));
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic step();
    int g;
    bit load;
    #1 compare();
    g = grant();
    load = !myv || YR;
    @(posedge clk);
    if (load && g >= 0) begin
      my = X[g*W +: W]; myc = g; myv = 1;
`ifdef MUX_RR_EN
      if (M) mp = (g + 1) % N;
`endif
    end else if (load) myv = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; V = 4'b1111; M = 0; S = 0; YR = 1;
    X = {$urandom, $urandom} ;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_R", 32'(R), 0);
    chk("rst_YV", 32'(YV), 0);
    chk("rst_Y", 32'(Y), 0);
    chk("rst_YC", 32'(YC), 0);
    @(negedge clk);
    rst = 0; V = 0;
    step(); step();
    chk("idle_YV", 32'(YV), 0);
    // Fixed select
    M = 0; S = 2; V = 4'b0100; X[2*W +: W] = 8'hA5; YR = 1;
    #1 chk("fix_R", 32'(R), 32'b0100);
    step();
    chk("fix_Y", 32'(Y), 32'hA5);
    chk("fix_YC", 32'(YC), 2);
    chk("fix_YV", 32'(YV), 1);
    V = 4'b1011;
    #1 chk("fix_noR", 32'(R), 0);
    step();
    chk("fix_YVfall", 32'(YV), 0);
`ifdef MUX_RR_EN
    M = 1; V = 4'b1111; YR = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_YC", 32'(YC), 32'(i % 4));
      chk("rr_YV", 32'(YV), 1);
    end
    step(); step();
    chk("rr_pre", 32'(YC), 2);
    V = 4'b0110;
    step();
    chk("rr_skip", 32'(YC), 1);
    step();
    chk("rr_next", 32'(YC), 2);
    V = 4'b1111; YR = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_YC", 32'(YC), 2);
      chk("bp_R", 32'(R), 0);
    end
    YR = 1;
    #1 chk("bp_resume_R", 32'(R), 32'b1000);
    step();
    chk("bp_resume_YC", 32'(YC), 3);
`else
    M = 1; S = 1; V = 4'b1111; YR = 1;
    for (int i = 0; i < 6; i++) begin
      YR = (i != 2);
      step();
      chk("cfg_YC", 32'(YC), 1);
    end
    YR = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_R", 32'(R), 0);
      chk("bp_YC", 32'(YC), 1);
    end
    YR = 1;
    #1 chk("bp_resume_R", 32'(R), 32'b0010);
    step();
`endif
    // Mid-stream reset with a held word
    YR = 0; V = 4'b1111; step();
    rst = 1;
    #1 model_reset();
    chk("mrst_YV", 32'(YV), 0);
    chk("mrst_Y", 32'(Y), 0);
    chk("mrst_R", 32'(R), 0);
    @(negedge clk);
    rst = 0; YR = 1;
    for (int c = 0; c < 3000; c++) begin
      X = {$urandom, $urandom};
      V = N'($urandom);
      M = 1'($urandom);
      S = SW'($urandom);
      YR = ($urandom % 4) != 0;
      if ($urandom % 150 == 0) begin
        rst = 1;
        #1 model_reset();
        compare();
        @(negedge clk);
        rst = 0;
      end else step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux_rr_n.md
MUX_RR_N -- requirements
Module: mux_rr_n

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel.
REQ-002 Parameter SW, default 2: select width; channel count N = 2**SW, so N = 4 by default.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port X, input, N*WIDTH bits: channel data; channel i occupies X[i*WIDTH +: WIDTH].
REQ-006 The module SHALL have port V, input, N bits: per-channel valid.
REQ-007 The module SHALL have port R, output, N bits: per-channel ready (accept strobe).
REQ-008 The module SHALL have port M, input, 1 bit: mode; 0 = fixed select, 1 = round-robin.
REQ-009 The module SHALL have port S, input, SW bits: channel select, used only when M = 0.
REQ-010 The module SHALL have port Y, output, WIDTH bits: registered output data.
REQ-011 The module SHALL have port YV, output, 1 bit: output valid.
REQ-012 The module SHALL have port YR, input, 1 bit: downstream ready.
REQ-013 The module SHALL have port YC, output, SW bits: index of the channel that sourced Y.

Function
REQ-014 The output SHALL be a one-entry register; load = ~YV | YR.
REQ-015 In fixed mode, the grant SHALL go to channel S iff V[S] = 1; otherwise no grant.
REQ-016 In round-robin mode, the grant SHALL go to the first i with V[i] = 1, scanning from pointer P upward and wrapping from N-1 to 0.
REQ-017 R[i] SHALL be combinational: R[i] = load & grant valid & grant == i; at most one bit of R is high.
REQ-018 A transfer SHALL occur on a cycle where R[i] & V[i]; on that edge Y <= channel i data, YC <= i, YV <= 1.
REQ-019 On a transfer in round-robin mode, P SHALL advance to (i+1) mod N, wrapping N-1 to 0; P SHALL hold otherwise, including in fixed mode.
REQ-020 If load = 1 and there is no grant, YV SHALL go to 0 on that edge; Y and YC SHALL hold their values.
REQ-021 On a simultaneous drain (YV & YR) and new grant, the new word SHALL be captured with no bubble, sustaining 1 word/cycle.
REQ-022 While YV = 1 and YR = 0: Y, YC and YV SHALL be stable, R SHALL be all 0, and P SHALL hold.
REQ-023 Latency SHALL be 1 cycle from a transfer edge to YV/Y visible.
REQ-024 A change of M or S SHALL affect only the current-cycle grant; it SHALL never alter a word already in the output register.
REQ-025 X values on channels with V = 0 SHALL never propagate to Y.

Reset
REQ-026 While rst = 1, the block SHALL force Y = 0, YC = 0, YV = 0 and P = 0 immediately, independent of clk.
REQ-027 R SHALL be all 0 while rst = 1.
REQ-028 A reset asserted mid-stream SHALL discard the held word with no transfer reported.
REQ-029 The first grant after reset release SHALL use P = 0.

Configuration
REQ-030 The behaviour SHALL depend on macro MUX_RR_EN as follows:
- Defined: round-robin mode and pointer P are present, as in REQ-016 and REQ-019.
- Undefined: P is not implemented, M is ignored, and the block always operates in fixed mode (REQ-015); all other behaviour is identical.

Verification
REQ-031 Reset/idle: hold rst = 1 with V = 4'b1111 -> R = 0, YV = 0, Y = 0, YC = 0; release with V = 0 -> YV stays 0.
REQ-032 Fixed select: M = 0, S = 2, V = 4'b0100, X[2] = 8'hA5, YR = 1 -> R = 4'b0100 for one cycle; next cycle Y = 8'hA5, YC = 2, YV = 1. With V = 4'b1011 and S = 2 -> R = 0 and YV falls.
REQ-033 Round-robin fairness: M = 1, V = 4'b1111 held, YR = 1 -> YC sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
REQ-034 Round-robin skip and wrap: P = 3, V = 4'b0110 -> grant channel 1, then P = 2 and the next grant goes to channel 2.
REQ-035 Backpressure: YV = 1, YR = 0 for 3 cycles with all V high -> Y, YC stable, R = 0, P unchanged; YR = 1 -> transfer and capture in the same cycle.
REQ-036 Config: build without MUX_RR_EN, M = 1, S = 1, V = 4'b1111 -> only channel 1 is ever granted.
